// File: rtl/adder_tree_csa_seq.sv
// Sequencer feeding long unsigned vectors through an external pipelined 4-input
// adder tree, four words per beat, accumulating one total per vector.
module adder_tree_csa_seq #(
    parameter int I_DATA_W  = 3,
    parameter int LANES     = 4,
    parameter int TREE_W    = I_DATA_W + 3,
    parameter int TREE_LAT  = 2,
    parameter int MAX_BEATS = 16,
    parameter int ACC_W     = TREE_W + $clog2(MAX_BEATS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [LANES*I_DATA_W-1:0]     s_data,
    input  logic [LANES-1:0]              s_keep,
    input  logic                          s_last,
    output logic [LANES*I_DATA_W-1:0]     tree_data,
    input  logic [TREE_W-1:0]             tree_sum,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [ACC_W-1:0]              o_data,
    output logic [$clog2(MAX_BEATS):0]    o_beats,
    output logic                          o_ovf
);

    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    typedef struct packed {
        logic vld;
        logic last;
        logic drop;
    } tag_t;

    logic [LANES*I_DATA_W-1:0] masked_data;
    logic [LANES*I_DATA_W-1:0] tree_data_q, tree_data_d;
    tag_t                      tag_q [TREE_LAT+1];
    tag_t                      tag0_d;
    tag_t                      tag_out;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic [CNT_W-1:0]          fin_beats_q, fin_beats_d;
    logic                      fin_ovf_q, fin_ovf_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [ACC_W-1:0]          sum_ext;
    logic [ACC_W-1:0]          acc_sum;
    logic                      o_valid_q, o_valid_d;
    logic [ACC_W-1:0]          o_data_q, o_data_d;
    logic [CNT_W-1:0]          o_beats_q, o_beats_d;
    logic                      o_ovf_q, o_ovf_d;
    logic                      any_last;
    logic                      accept;
    logic                      at_max;

    always_comb begin
        masked_data = '0;
        for (int k = 0; k < LANES; k++) begin
            masked_data[k*I_DATA_W +: I_DATA_W] =
                s_keep[k] ? s_data[k*I_DATA_W +: I_DATA_W] : '0;
        end
    end

    // A last beat anywhere in the pipe blocks intake, so only one vector can be finishing.
    always_comb begin
        any_last = 1'b0;
        for (int i = 0; i <= TREE_LAT; i++) begin
            any_last = any_last | (tag_q[i].vld & tag_q[i].last);
        end
    end

    assign s_ready = !any_last && !o_valid_q;
    assign accept  = s_valid && s_ready;
    assign at_max  = (cnt_q == CNT_W'(MAX_BEATS));

    always_comb begin
        tree_data_d = tree_data_q;
        tag0_d      = '0;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        fin_beats_d = fin_beats_q;
        fin_ovf_d   = fin_ovf_q;
        if (accept) begin
            tree_data_d = masked_data;
            tag0_d.vld  = 1'b1;
            tag0_d.last = s_last;
            tag0_d.drop = at_max;
            if (s_last) begin
                cnt_d       = '0;
                ovf_d       = 1'b0;
                fin_beats_d = at_max ? cnt_q : cnt_q + CNT_W'(1);
                fin_ovf_d   = ovf_q | at_max;
            end else if (at_max) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign tag_out = tag_q[TREE_LAT];
    assign sum_ext = tag_out.drop ? '0 : ACC_W'(tree_sum);
    assign acc_sum = acc_q + sum_ext;

    // A freshly loaded result takes precedence over clearing the previous one.
    always_comb begin
        acc_d     = acc_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_beats_d = o_beats_q;
        o_ovf_d   = o_ovf_q;
        if (o_valid_q && o_ready) begin
            o_valid_d = 1'b0;
        end
        if (tag_out.vld) begin
            if (tag_out.last) begin
                o_valid_d = 1'b1;
                o_data_d  = acc_sum;
                o_beats_d = fin_beats_q;
                o_ovf_d   = fin_ovf_q;
                acc_d     = '0;
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tree_data_q <= '0;
            for (int i = 0; i <= TREE_LAT; i++) begin
                tag_q[i] <= '0;
            end
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            fin_beats_q <= '0;
            fin_ovf_q   <= 1'b0;
            acc_q       <= '0;
            o_valid_q   <= 1'b0;
            o_data_q    <= '0;
            o_beats_q   <= '0;
            o_ovf_q     <= 1'b0;
        end else begin
            tree_data_q <= tree_data_d;
            tag_q[0]    <= tag0_d;
            for (int i = 1; i <= TREE_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            fin_beats_q <= fin_beats_d;
            fin_ovf_q   <= fin_ovf_d;
            acc_q       <= acc_d;
            o_valid_q   <= o_valid_d;
            o_data_q    <= o_data_d;
            o_beats_q   <= o_beats_d;
            o_ovf_q     <= o_ovf_d;
        end
    end

    assign tree_data = tree_data_q;
    assign o_valid   = o_valid_q;
    assign o_data    = o_data_q;
    assign o_beats   = o_beats_q;
    assign o_ovf     = o_ovf_q;

endmodule

// File: tb/tb_adder_tree_csa_seq.sv
// Bench for adder_tree_csa_seq: behavioural adder tree, per-vector total model,
// and a cycle model of the ready/valid timing.
module tb_adder_tree_csa_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [11:0] s_data = '0;
    logic [3:0]  s_keep = '0;
    logic        s_last = 1'b0;
    logic [11:0] tree_data;
    logic [5:0]  tree_sum;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic [9:0]  o_data;
    logic [4:0]  o_beats;
    logic        o_ovf;

    adder_tree_csa_seq dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_keep    (s_keep),
        .s_last    (s_last),
        .tree_data (tree_data),
        .tree_sum  (tree_sum),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_beats   (o_beats),
        .o_ovf     (o_ovf)
    );

    always #5 clk = ~clk;

    function automatic int lane_sum(input logic [11:0] d, input logic [3:0] k);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) s += int'(d[i*3 +: 3]);
        end
        return s;
    endfunction

    // Two-stage tree model: tree_sum follows tree_data by two edges.
    logic [5:0] t1, t2;
    always @(posedge clk) begin
        t1 <= 6'(lane_sum(tree_data, 4'hF));
        t2 <= t1;
    end
    assign tree_sum = t2;

    typedef struct { logic [11:0] data; logic [3:0] keep; logic last; } beat_t;
    typedef struct { int total; int beats; int ovf; } res_t;
    beat_t bq[$];
    res_t  eq[$];

    int n_pass = 0;
    int n_tot  = 0;
    int v_n = 0, v_total = 0, v_ovf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Only the first 16 beats of a vector count; any beyond mark overflow.
    task automatic push_beat(input logic [11:0] d, input logic [3:0] k, input logic last);
        beat_t b;
        res_t  r;
        b.data = d; b.keep = k; b.last = last;
        bq.push_back(b);
        v_n++;
        if (v_n <= 16) v_total += lane_sum(d, k);
        else v_ovf = 1;
        if (last) begin
            r.total = v_total;
            r.beats = (v_n > 16) ? 16 : v_n;
            r.ovf   = v_ovf;
            eq.push_back(r);
            v_n = 0; v_total = 0; v_ovf = 0;
        end
    endtask

    task automatic run(input int gap_pct, input int rdy_pct, input int hold, input int max_cyc);
        int    cyc = 0;
        int    t_last = 0;
        bit    pend = 0;
        bit    exp_ov, acc_hs, hs;
        beat_t b;
        s_valid = 1'b0;
        while (bq.size() != 0 || s_valid || pend) begin
            if (cyc >= max_cyc) begin
                chk("timeout", 32'd1, 32'd0);
                break;
            end
            if (!s_valid && bq.size() != 0 && $urandom_range(99) >= gap_pct) begin
                b = bq.pop_front();
                s_valid = 1'b1; s_data = b.data; s_keep = b.keep; s_last = b.last;
            end
            // o_valid rises after the third edge following the edge that took the last beat.
            exp_ov  = pend && ((cyc - t_last) > 3);
            o_ready = (exp_ov ? ((cyc - t_last - 4) >= hold) : 1'b1)
                      && ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            chk("s_ready", 32'(s_ready), 32'(!pend));
            chk("o_valid", 32'(o_valid), 32'(exp_ov));
            if (exp_ov) begin
                if (eq.size() == 0) begin
                    chk("result_queue", 32'd0, 32'd1);
                end else begin
                    chk("o_data",  32'(o_data),  32'(eq[0].total));
                    chk("o_beats", 32'(o_beats), 32'(eq[0].beats));
                    chk("o_ovf",   32'(o_ovf),   32'(eq[0].ovf));
                end
            end
            acc_hs = s_valid && !pend;
            hs     = exp_ov && o_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                void'(eq.pop_front());
                pend = 0;
            end
            if (acc_hs) begin
                if (s_last) begin
                    pend = 1;
                    t_last = cyc;
                end
                s_valid = 1'b0;
            end
            cyc++;
        end
        s_valid = 1'b0;
        o_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"},   32'(s_ready),   32'd1);
        chk({tag, "_tree_data"}, 32'(tree_data), 32'd0);
        chk({tag, "_o_valid"},   32'(o_valid),   32'd0);
        chk({tag, "_o_data"},    32'(o_data),    32'd0);
        chk({tag, "_o_beats"},   32'(o_beats),   32'd0);
        chk({tag, "_o_ovf"},     32'(o_ovf),     32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst_init");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single beat of all 7s.
        push_beat(12'hFFF, 4'hF, 1'b1);
        run(0, 100, 0, 50);

        // {1,2,3,4} full keep, then {5,6,7,7} with only lanes 0..1 kept.
        push_beat({3'd4, 3'd3, 3'd2, 3'd1}, 4'hF, 1'b0);
        push_beat({3'd7, 3'd7, 3'd6, 3'd5}, 4'h3, 1'b1);
        run(0, 100, 0, 50);

        // Exactly MAX_BEATS, then one beyond.
        for (int i = 0; i < 16; i++) push_beat(12'hFFF, 4'hF, i == 15);
        run(0, 100, 0, 100);
        for (int i = 0; i < 17; i++) push_beat(12'hFFF, 4'hF, i == 16);
        run(0, 100, 0, 100);

        // Back-to-back vectors with the consumer stalled for 5 cycles.
        for (int i = 0; i < 3; i++) push_beat(12'(i * 389 + 77), 4'hF, i == 2);
        for (int i = 0; i < 2; i++) push_beat(12'(i * 1234 + 5), 4'h5, i == 1);
        run(0, 100, 5, 100);

        // All-zero keep vector.
        push_beat(12'hFFF, 4'h0, 1'b0);
        push_beat(12'h123, 4'h0, 1'b1);
        run(0, 100, 0, 50);

        // Random vectors, random gaps, random consumer.
        for (int v = 0; v < 200; v++) begin
            n = $urandom_range(16, 1);
            for (int i = 0; i < n; i++) push_beat(12'($urandom), 4'($urandom), i == n - 1);
        end
        run(30, 70, 0, 20000);

        // Reset with beats in flight.
        o_ready = 1'b1;
        s_valid = 1'b1; s_data = 12'hFFF; s_keep = 4'hF; s_last = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        #1 rst = 1'b1;
        #1 chk_reset_outputs("rst_pipe");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_beat({3'd1, 3'd1, 3'd1, 3'd1}, 4'hF, 1'b1);
        run(0, 100, 0, 50);

        // Reset while a result is pending.
        o_ready = 1'b0;
        s_valid = 1'b1; s_data = 12'hFFF; s_keep = 4'hF; s_last = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pending_o_valid", 32'(o_valid), 32'd1);
        chk("pending_o_data",  32'(o_data),  32'd28);
        rst = 1'b1;
        #1 chk_reset_outputs("rst_result");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_beat({3'd2, 3'd0, 3'd3, 3'd1}, 4'hF, 1'b0);
        push_beat({3'd1, 3'd1, 3'd1, 3'd1}, 4'h8, 1'b1);
        run(0, 100, 0, 50);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
